// File: rtl/hp2_rd_addr_gen_pkg.sv
// Shared types and AXI constants for the HP2 read-address generator.
// Includes the FSM encoding and the burst-length clamp helper.
package hp2_rd_addr_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] AXSIZE_8B    = 3'd3;
  localparam logic [1:0] AXBURST_INCR = 2'b01;

  // Requested beats (0 means 1), clipped to the beats still unrequested.
  function automatic logic [3:0] burst_len(
    input logic [3:0]  req,
    input logic [31:0] rem
  );
    logic [3:0] b;
    b = (req == 4'd0) ? 4'd1 : req;
    if (rem < 32'(b)) burst_len = rem[3:0];
    else              burst_len = b;
  endfunction

endpackage

// File: rtl/hp2_len_fifo.sv
// Small synchronous FIFO holding the length of each issued AR burst.
// Push and pop may happen together; push is dropped when full.
import hp2_rd_addr_gen_pkg::*;

module hp2_len_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [3:0] din,
  input  logic       pop,
  output logic [3:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int PW = $clog2(DEPTH);

  logic [3:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [PW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/hp2_rd_addr_gen.sv
// AXI HP2 read-address generator for the RDMA2 path.
// Issues AR bursts for one layer and forwards accepted R beats.
import hp2_rd_addr_gen_pkg::*;

module hp2_rd_addr_gen #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TOT_W   = 20,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [TOT_W-1:0]  total_beats,
  input  logic [3:0]        burst_beats,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic              m_rvalid,
  input  logic              m_rlast,
  output logic              m_rready,
  output logic              rdma2_valid,
  output logic              rdma2_done,
  output logic              busy,
  output logic              rlast_err
);

  localparam int BSH = $clog2(DATA_W / 8);
  localparam int OW  = $clog2(MAX_OUT) + 1;
  localparam logic [2:0] ARSIZE =
    (DATA_W == 64) ? AXSIZE_8B : 3'(BSH);

  state_t state;
  state_t state_n;

  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen_q;
  logic [3:0]        len_q;
  logic              arvalid_q;
  logic [TOT_W-1:0]  rem_ar;
  logic [TOT_W-1:0]  rem_r;
  logic [OW-1:0]     out_cnt;
  logic [4:0]        beat_cnt;
  logic              err_q;

  logic       ar_hs;
  logic       r_hs;
  logic       rl_hs;
  logic       start_ok;
  logic       last_ar;
  logic       ar_launch;
  logic [3:0] len_now;
  logic [3:0] hd_len;
  logic [4:0] last_idx;
  logic       f_full;
  logic       f_empty;

  assign m_araddr    = araddr;
  assign m_arlen     = arlen_q;
  assign m_arsize    = ARSIZE;
  assign m_arburst   = AXBURST_INCR;
  assign m_arvalid   = arvalid_q;
  assign busy        = (state != ST_IDLE);
  assign m_rready    = busy;
  assign rdma2_valid = m_rvalid & m_rready;
  assign rdma2_done  = (state == ST_DONE);
  assign rlast_err   = err_q;

  assign ar_hs    = arvalid_q & m_arready;
  assign r_hs     = rdma2_valid;
  assign rl_hs    = r_hs & m_rlast;
  assign start_ok = start & (state == ST_IDLE);
  assign last_ar  = (rem_ar == TOT_W'(len_q));
  assign len_now  = burst_len(burst_beats, 32'(rem_ar));
  assign last_idx = {1'b0, hd_len} - 5'd1;

  // A request is raised only from an idle AR channel, so a
  // handshake is always followed by one quiet cycle.
  assign ar_launch = (state == ST_ISSUE) & ~arvalid_q
                   & (out_cnt < OW'(MAX_OUT))
                   & (rem_ar != '0) & ~f_full;

  hp2_len_fifo #(
    .DEPTH (MAX_OUT)
  ) u_len_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ar_hs),
    .din   (len_q),
    .pop   (rl_hs),
    .dout  (hd_len),
    .full  (f_full),
    .empty (f_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (start)
          state_n = (total_beats == '0) ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (ar_hs && last_ar) state_n = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (rl_hs && out_cnt == OW'(1)) state_n = ST_DONE;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      araddr    <= '0;
      arlen_q   <= '0;
      len_q     <= '0;
      arvalid_q <= 1'b0;
      rem_ar    <= '0;
      rem_r     <= '0;
      out_cnt   <= '0;
      beat_cnt  <= '0;
      err_q     <= 1'b0;
    end else if (start_ok) begin
      araddr    <= base_addr;
      rem_ar    <= total_beats;
      rem_r     <= total_beats;
      arvalid_q <= 1'b0;
      out_cnt   <= '0;
      beat_cnt  <= '0;
      err_q     <= 1'b0;
    end else begin
      if (ar_launch) begin
        arvalid_q <= 1'b1;
        len_q     <= len_now;
        arlen_q   <= {4'd0, len_now - 4'd1};
      end else if (ar_hs) begin
        arvalid_q <= 1'b0;
        araddr    <= araddr + (ADDR_W'(len_q) << BSH);
        rem_ar    <= rem_ar - TOT_W'(len_q);
      end

      case ({ar_hs, rl_hs})
        2'b10: out_cnt <= out_cnt + 1'b1;
        2'b01: if (out_cnt != '0) out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase

      if (r_hs) begin
        if (rem_r != '0) rem_r <= rem_r - 1'b1;
        if (m_rlast) begin
          beat_cnt <= '0;
          if (f_empty || beat_cnt != last_idx) err_q <= 1'b1;
        end else begin
          if (beat_cnt != 5'd31) beat_cnt <= beat_cnt + 1'b1;
          if (f_empty || beat_cnt >= last_idx) err_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hp2_rd_addr_gen.sv
// Self-checking bench for hp2_rd_addr_gen.
// An AXI slave model answers ARs; layers are checked against arithmetic.
module tb_hp2_rd_addr_gen;

  localparam int MAX_OUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [19:0] total_beats = '0;
  logic [3:0]  burst_beats = '0;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic        m_rvalid = 1'b0;
  logic        m_rlast = 1'b0;
  logic        m_rready;
  logic        rdma2_valid;
  logic        rdma2_done;
  logic        busy;
  logic        rlast_err;

  always #5 clk = ~clk;

  hp2_rd_addr_gen #(
    .ADDR_W(32), .DATA_W(64), .TOT_W(20), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .total_beats(total_beats),
    .burst_beats(burst_beats),
    .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rlast(m_rlast),
    .m_rready(m_rready), .rdma2_valid(rdma2_valid),
    .rdma2_done(rdma2_done), .busy(busy),
    .rlast_err(rlast_err)
  );

  int errors = 0;
  int checks = 0;

  bit ar_rand = 0;
  bit ar_force = 1;
  bit r_en = 1;
  bit r_rand = 0;
  int short_next = 0;
  int pend[$];
  int bidx = 0;
  int cyc = 0;
  int ar_tot = 0;
  int rl_tot = 0;
  int beats = 0;
  int done_cnt = 0;
  int simult = 0;
  int prot_viol = 0;
  int last_ar_cyc = -10;
  logic [31:0] aq_addr[$];
  logic [7:0]  aq_len[$];
  bit prev_stall = 0;
  logic [31:0] prev_addr;
  logic [7:0]  prev_len;

  task automatic bfm();
    bit arh;
    bit rh;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pend.delete();
        bidx = 0;
        ar_tot = 0;
        rl_tot = 0;
        prev_stall = 0;
      end
      m_arready = ar_rand ? 1'($urandom_range(0, 1)) : ar_force;
      if (r_en && pend.size() > 0 &&
          (!r_rand || $urandom_range(0, 2) != 0)) begin
        m_rvalid = 1'b1;
        m_rlast  = (bidx == pend[0] - 1);
      end else begin
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
      end
      #1;
      if (prev_stall && (!m_arvalid || m_araddr !== prev_addr ||
                         m_arlen !== prev_len))
        prot_viol++;
      if (m_arvalid && (ar_tot - rl_tot) >= MAX_OUT) prot_viol++;
      if (rdma2_valid !== (m_rvalid & m_rready)) prot_viol++;
      prev_stall = m_arvalid && !m_arready;
      prev_addr  = m_araddr;
      prev_len   = m_arlen;
      arh = m_arvalid && m_arready;
      rh  = m_rvalid && m_rready;
      if (rh) begin
        beats++;
        bidx++;
        if (m_rlast) begin
          void'(pend.pop_front());
          bidx = 0;
          rl_tot++;
        end
      end
      if (arh) begin
        aq_addr.push_back(m_araddr);
        aq_len.push_back(m_arlen);
        if (short_next > 0) begin
          pend.push_back(short_next);
          short_next = 0;
        end else begin
          pend.push_back(int'(m_arlen) + 1);
        end
        if (cyc - last_ar_cyc < 2) prot_viol++;
        last_ar_cyc = cyc;
        ar_tot++;
      end
      if (arh && rh && m_rlast) simult++;
      if (rdma2_done) done_cnt++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic begin_layer();
    aq_addr.delete();
    aq_len.delete();
    beats = 0;
    done_cnt = 0;
    prot_viol = 0;
    last_ar_cyc = -10;
  endtask

  task automatic start_layer(input logic [31:0] b, input int t,
                             input int bb);
    @(negedge clk);
    base_addr   = b;
    total_beats = 20'(t);
    burst_beats = 4'(bb);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s_timeout: done_cnt=%0d after %0d cycles, required >%0d",
               nm, done_cnt, budget, d0);
    end
  endtask

  task automatic check_layer(input string nm, input logic [31:0] b,
                             input int t, input int bb);
    int bw;
    int rem;
    int len;
    int i;
    int nexp;
    logic [31:0] a;
    bw = (bb == 0) ? 1 : bb;
    nexp = (t + bw - 1) / bw;
    checks++;
    if (aq_len.size() != nexp) begin
      errors++;
      $display("FAIL %s_ar_count: got %0d, required %0d",
               nm, aq_len.size(), nexp);
    end
    rem = t;
    a = b;
    i = 0;
    while (rem > 0) begin
      len = (rem < bw) ? rem : bw;
      if (i < aq_len.size()) begin
        checks++;
        if (aq_addr[i] !== a || aq_len[i] !== 8'(len - 1)) begin
          errors++;
          $display("FAIL %s_ar%0d: got addr=%h len=%0d, required addr=%h len=%0d",
                   nm, i, aq_addr[i], aq_len[i], a, len - 1);
        end
      end
      a = a + 32'(len * 8);
      rem = rem - len;
      i++;
    end
    checks++;
    if (beats != t) begin
      errors++;
      $display("FAIL %s_beats: got %0d, required %0d", nm, beats, t);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s_done_cnt: got %0d, required 1", nm, done_cnt);
    end
    checks++;
    if (rlast_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_end_flags: got err=%b busy=%b, required 0 0",
               nm, rlast_err, busy);
    end
    checks++;
    if (prot_viol != 0) begin
      errors++;
      $display("FAIL %s_protocol: got %0d violations, required 0",
               nm, prot_viol);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (m_araddr !== 32'd0 || m_arlen !== 8'd0 || m_arvalid !== 1'b0 ||
        m_rready !== 1'b0 || rdma2_valid !== 1'b0 ||
        rdma2_done !== 1'b0 || busy !== 1'b0 || rlast_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%h len=%h v=%b rr=%b rv=%b d=%b b=%b e=%b, required all 0",
               m_araddr, m_arlen, m_arvalid, m_rready, rdma2_valid,
               rdma2_done, busy, rlast_err);
    end
    checks++;
    if (m_arsize !== 3'd3 || m_arburst !== 2'b01) begin
      errors++;
      $display("FAIL reset_consts: got size=%0d burst=%0d, required 3 1",
               m_arsize, m_arburst);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_reset();
    begin_layer();
    ar_rand = 0; ar_force = 1; r_en = 1; r_rand = 0;
    start_layer(32'h1000_0000, 40, 4);
    #2;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got %b, required 1", busy);
    end
    wait_done("basic", 400);
    @(negedge clk); #2;
    check_layer("basic", 32'h1000_0000, 40, 4);
  endtask

  task automatic test_tail();
    do_reset();
    begin_layer();
    start_layer(32'h2000_0100, 13, 5);
    wait_done("tail", 300);
    @(negedge clk); #2;
    check_layer("tail", 32'h2000_0100, 13, 5);
    checks++;
    if (aq_addr.size() < 3 || aq_addr[2] !== 32'h2000_0150) begin
      errors++;
      $display("FAIL tail_last_addr: got %h, required %h",
               (aq_addr.size() > 2) ? aq_addr[2] : 32'hx, 32'h2000_0150);
    end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    begin_layer();
    ar_force = 0; r_en = 0;
    start_layer(32'h3000_0000, 32, 4);
    repeat (12) @(negedge clk);
    #2;
    checks++;
    if (m_arvalid !== 1'b1 || aq_len.size() != 0 || prot_viol != 0) begin
      errors++;
      $display("FAIL bp_stall: got v=%b ars=%0d viol=%0d, required 1 0 0",
               m_arvalid, aq_len.size(), prot_viol);
    end
    ar_force = 1;
    repeat (20) @(negedge clk);
    #2;
    checks++;
    if (aq_len.size() != MAX_OUT || m_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_max_out: got ars=%0d v=%b, required %0d 0",
               aq_len.size(), m_arvalid, MAX_OUT);
    end
    r_en = 1;
    n = 0;
    while (rl_tot < 1 && n < 30) begin @(negedge clk); #2; n++; end
    n = 0;
    while (aq_len.size() < MAX_OUT + 1 && n < 8) begin
      @(negedge clk); #2; n++;
    end
    checks++;
    if (aq_len.size() < MAX_OUT + 1) begin
      errors++;
      $display("FAIL bp_slot_free: got ars=%0d, required %0d",
               aq_len.size(), MAX_OUT + 1);
    end
    wait_done("bp", 500);
    @(negedge clk); #2;
    check_layer("bp", 32'h3000_0000, 32, 4);
  endtask

  task automatic test_random();
    logic [31:0] b;
    int t;
    int bb;
    simult = 0;
    ar_rand = 1; r_rand = 1;
    for (int k = 0; k < 6; k++) begin
      do_reset();
      begin_layer();
      b  = $urandom & 32'hFFFF_FFF8;
      t  = $urandom_range(20, 120);
      bb = $urandom_range(0, 15);
      start_layer(b, t, bb);
      wait_done("rand", 3000);
      @(negedge clk); #2;
      check_layer("rand", b, t, bb);
    end
    ar_rand = 0; r_rand = 0; ar_force = 1;
    checks++;
    if (simult == 0) begin
      errors++;
      $display("FAIL rand_simult: got %0d same-cycle AR/rlast, required >0",
               simult);
    end
  endtask

  task automatic test_rlast_err();
    do_reset();
    begin_layer();
    short_next = 3;
    start_layer(32'h4000_0000, 5, 5);
    wait_done("err", 200);
    #2;
    checks++;
    if (rlast_err !== 1'b1 || beats != 3) begin
      errors++;
      $display("FAIL err_set: got err=%b beats=%0d, required 1 3",
               rlast_err, beats);
    end
    repeat (5) @(negedge clk);
    #2;
    checks++;
    if (rlast_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b, required 1", rlast_err);
    end
    begin_layer();
    start_layer(32'h4000_1000, 4, 4);
    #2;
    checks++;
    if (rlast_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b, required 0", rlast_err);
    end
    wait_done("err2", 200);
    @(negedge clk); #2;
    check_layer("err2", 32'h4000_1000, 4, 4);
  endtask

  task automatic test_zero_len();
    do_reset();
    begin_layer();
    @(negedge clk);
    base_addr = 32'h5000_0000;
    total_beats = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2;
    checks++;
    if (rdma2_done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_done: got done=%b busy=%b, required 1 1",
               rdma2_done, busy);
    end
    @(negedge clk); #2;
    checks++;
    if (rdma2_done !== 1'b0 || done_cnt != 1 ||
        aq_len.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_after: got done=%b cnt=%0d ars=%0d busy=%b, required 0 1 0 0",
               rdma2_done, done_cnt, aq_len.size(), busy);
    end
  endtask

  task automatic test_start_busy();
    do_reset();
    begin_layer();
    start_layer(32'h6000_0000, 16, 4);
    repeat (3) @(negedge clk);
    base_addr = 32'h7000_0000;
    total_beats = 20'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start", 300);
    repeat (10) @(negedge clk);
    #2;
    check_layer("busy_start", 32'h6000_0000, 16, 4);
  endtask

  task automatic test_reset_mid();
    do_reset();
    begin_layer();
    ar_force = 0; r_en = 0;
    start_layer(32'h8000_0000, 64, 8);
    repeat (4) @(negedge clk);
    #2;
    checks++;
    if (m_arvalid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: got arvalid=%b, required 1", m_arvalid);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #2;
    checks++;
    if (m_arvalid !== 1'b0 || m_araddr !== 32'd0 || m_arlen !== 8'd0 ||
        busy !== 1'b0 || m_rready !== 1'b0 || rdma2_done !== 1'b0 ||
        rlast_err !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs: got v=%b a=%h l=%h b=%b rr=%b d=%b e=%b, required all 0",
               m_arvalid, m_araddr, m_arlen, busy, m_rready,
               rdma2_done, rlast_err);
    end
    rst = 1'b0;
    ar_force = 1; r_en = 1;
    @(negedge clk);
    begin_layer();
    start_layer(32'h8000_0400, 8, 8);
    wait_done("rstmid", 200);
    @(negedge clk); #2;
    check_layer("rstmid", 32'h8000_0400, 8, 8);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      bfm();
    join_none
    test_reset();
    test_basic();
    test_tail();
    test_backpressure();
    test_random();
    test_rlast_err();
    test_zero_len();
    test_start_busy();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
